// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg
//   Shared definitions for the 2:1 mux round-robin arbiter: FSM state
//   encoding and the mux select polarity.
//   The select encoding is also used to name sides (last owner, switch
//   target), so "last_q == SEL_A" reads as "A owned the mux last".
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2,
    ST_DEAD  = 2'd3
  } arb_state_e;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  // Grant state belonging to a side, given in select encoding.
  function automatic arb_state_e gnt_state(input logic side);
    return (side == SEL_A) ? ST_GNT_A : ST_GNT_B;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
//   Two-way round-robin pick. A lone requester wins; on a tie the side
//   that did not own the mux last wins. At most one pick output is high.
// Ports
//   req_a_i, req_b_i : request levels
//   last_i           : last owner, select encoding (SEL_A / SEL_B)
//   pick_a_o         : A wins this arbitration
//   pick_b_o         : B wins this arbitration
import mux_arb_pkg::*;

module rr_pick2 (
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_i,
  output logic pick_a_o,
  output logic pick_b_o
);

  assign pick_a_o = req_a_i & (~req_b_i | (last_i == SEL_B));
  assign pick_b_o = req_b_i & (~req_a_i | (last_i == SEL_A));

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
//   Shares one 2:1 transmission-gate mux between requesters A and B.
//   Round-robin on ties, bounded burst while the other side waits, and
//   break-before-make on the select: every source change passes through
//   DEAD_CYC cycles with both grants low.
// Parameters
//   BURST_MAX : max consecutive granted cycles while the other side requests
//   DEAD_CYC  : dead cycles on a source switch
//   CNT_W     : counter width, holds max(BURST_MAX, DEAD_CYC)
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_a, req_b      : request levels, held while wanted
//   grant_a, grant_b  : registered ownership this cycle
//   sel               : mux enable, 1 = A passes, 0 = B passes
//   out_en            : grant_a | grant_b
//   busy              : FSM not idle
import mux_arb_pkg::*;

module mux2_rr_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int DEAD_CYC  = 1,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b,
  output logic sel,
  output logic out_en,
  output logic busy
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYC - 1);

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;    // previous owner
  logic             tgt_q;     // side a DEAD period switches toward
  logic             grant_a_q;
  logic             grant_b_q;
  logic             sel_q;

  logic pick_a, pick_b, pick_side;

  // IDLE and the end of DEAD both arbitrate against last_q.
  rr_pick2 u_pick (
    .req_a_i  (req_a),
    .req_b_i  (req_b),
    .last_i   (last_q),
    .pick_a_o (pick_a),
    .pick_b_o (pick_b)
  );

  assign pick_side = pick_a ? SEL_A : SEL_B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_q    <= SEL_B;
      tgt_q     <= SEL_B;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      sel_q     <= SEL_B;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Output is already off, so sel may load together with the grant.
          if (pick_a || pick_b) begin
            state_q   <= gnt_state(pick_side);
            grant_a_q <= pick_a;
            grant_b_q <= pick_b;
            sel_q     <= pick_side;
            cnt_q     <= '0;
          end
        end

        ST_GNT_A: begin
          if (!req_a || (req_b && cnt_q == BURST_LAST)) begin
            grant_a_q <= 1'b0;
            last_q    <= SEL_A;
            cnt_q     <= '0;
            if (req_b) begin
              // Grant drops and sel flips on the same edge; the mux is
              // disabled for the whole DEAD period that follows.
              state_q <= ST_DEAD;
              tgt_q   <= SEL_B;
              sel_q   <= SEL_B;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (cnt_q != BURST_LAST) begin
            // Saturates: a lone holder keeps the mux indefinitely.
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_GNT_B: begin
          if (!req_b || (req_a && cnt_q == BURST_LAST)) begin
            grant_b_q <= 1'b0;
            last_q    <= SEL_B;
            cnt_q     <= '0;
            if (req_a) begin
              state_q <= ST_DEAD;
              tgt_q   <= SEL_A;
              sel_q   <= SEL_A;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (cnt_q != BURST_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            cnt_q <= '0;
            if (!(pick_a || pick_b)) begin
              state_q <= ST_IDLE;
            end else if (pick_side == tgt_q) begin
              // sel already points at the winner.
              state_q   <= gnt_state(pick_side);
              grant_a_q <= pick_a;
              grant_b_q <= pick_b;
            end else begin
              // Target gave up; switch toward the other side with a fresh
              // dead period. The abandoned target is recorded as last so a
              // later tie resolves toward the new target and cannot bounce.
              tgt_q  <= pick_side;
              sel_q  <= pick_side;
              last_q <= tgt_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          grant_a_q <= 1'b0;
          grant_b_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_a = grant_a_q;
  assign grant_b = grant_b_q;
  assign sel     = sel_q;
  assign out_en  = grant_a_q | grant_b_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter
//   Directed sequences plus a random request stream, each cycle compared
//   against an ownership/turn model of the arbiter.
module tb_mux2_rr_arbiter;

  localparam int BURST = 4;
  localparam int DEAD  = 1;
  localparam int WAIT_MAX = BURST + DEAD + 1;

  logic clk, rst_n, req_a, req_b;
  logic grant_a, grant_b, sel, out_en, busy;

  mux2_rr_arbiter #(.BURST_MAX(BURST), .DEAD_CYC(DEAD), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .grant_a(grant_a), .grant_b(grant_b), .sel(sel),
    .out_en(out_en), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: owner 0=A, 1=B, -1=none. m_run = granted cycles in current burst.
  int m_own, m_run, m_el, m_tgt, m_last;
  bit m_dead, m_sel;
  bit prev_oe, prev_sel;
  int wait_c[2];

  function automatic int arb(bit ra, bit rb, int last);
    if (ra && rb) return (last == 0) ? 1 : 0;
    if (ra) return 0;
    if (rb) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_run = 0; m_el = 0; m_tgt = 1; m_last = 1;
    m_dead = 0; m_sel = 0;
    prev_oe = 0; prev_sel = 0;
    wait_c[0] = 0; wait_c[1] = 0;
  endtask

  task automatic model_edge(input bit ra, input bit rb);
    bit r[2];
    int w, o, x;
    r[0] = ra; r[1] = rb;
    if (m_dead) begin
      if (m_el + 1 >= DEAD) begin
        m_el = 0;
        w = arb(ra, rb, m_last);
        if (w < 0) m_dead = 0;
        else if (w == m_tgt) begin m_dead = 0; m_own = w; m_run = 1; end
        else begin m_tgt = w; m_sel = (w == 0); m_last = 1 - w; end
      end else m_el++;
    end else if (m_own >= 0) begin
      o = m_own; x = 1 - o;
      if (!r[o] || (r[x] && m_run >= BURST)) begin
        m_last = o; m_own = -1;
        if (r[x]) begin m_dead = 1; m_el = 0; m_tgt = x; m_sel = (x == 0); end
      end else m_run++;
    end else begin
      w = arb(ra, rb, m_last);
      if (w >= 0) begin m_own = w; m_run = 1; m_sel = (w == 0); end
    end
  endtask

  function automatic logic [4:0] dut_vec();
    return {grant_a, grant_b, sel, out_en, busy};
  endfunction

  function automatic logic [4:0] mdl_vec();
    return {m_own == 0, m_own == 1, m_sel, m_own >= 0, (m_own >= 0) || m_dead};
  endfunction

  // One-letter view: A/B granted, a/b dead with sel toward A/B, I idle.
  function automatic byte obs_char();
    if (grant_a && !grant_b && sel && out_en && busy) return "A";
    if (grant_b && !grant_a && !sel && out_en && busy) return "B";
    if (!out_en && !grant_a && !grant_b && busy) return sel ? "a" : "b";
    if (!out_en && !grant_a && !grant_b && !busy) return "I";
    return "?";
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit ra, input bit rb);
    bit r[2], g[2];
    req_a = ra; req_b = rb;
    @(posedge clk);
    model_edge(ra, rb);
    @(negedge clk);
    chk("outs", 32'(dut_vec()), 32'(mdl_vec()));
    chk("mutex", 32'(grant_a & grant_b), 32'd0);
    chk("out_en", 32'(out_en), 32'(grant_a | grant_b));
    if (prev_oe && out_en) chk("sel_stable", 32'(sel), 32'(prev_sel));
    r[0] = ra; r[1] = rb; g[0] = grant_a; g[1] = grant_b;
    for (int s = 0; s < 2; s++) begin
      if (r[s] && !g[s]) wait_c[s]++;
      else begin
        if (g[s] && wait_c[s] > 0) chk("wait_bound", 32'(wait_c[s] <= WAIT_MAX), 32'd1);
        wait_c[s] = 0;
      end
    end
    prev_oe = out_en; prev_sel = sel;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("reset_state", 32'(dut_vec()), 32'd0);
  endtask

  task automatic run_seq(input string tag, input string ra, input string rb, input string ex);
    for (int i = 0; i < ex.len(); i++) begin
      step(ra[i] == 8'h31, rb[i] == 8'h31);
      chk($sformatf("%s[%0d]", tag, i), 32'(obs_char()), 32'(ex[i]));
    end
  endtask

  initial begin
    bit rq[2];
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    model_reset();
    #1 chk("por_async", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-grant, checked between clock edges.
    do_reset();
    run_seq("t1_pre", "11", "00", "AA");
    #1 rst_n = 1'b0;
    #1 chk("t1_async", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Lone A: 1-cycle latency, drop to idle with no dead period.
    do_reset();
    run_seq("t2", "111110", "000000", "AAAAAI");

    // Both from reset: A wins first, bursts of 4, dead 1 between.
    do_reset();
    run_seq("t3", "111111111110", "111111111110", "AAAAbBBBBaAI");

    // B releases while A waits.
    do_reset();
    run_seq("t4", "001110", "110000", "BBaAAI");

    // Target A gives up during DEAD: second dead period back to B.
    do_reset();
    run_seq("t5", "001000", "110110", "BBabBI");

    // Random streams; requests held until served, released while granted.
    do_reset();
    rq[0] = 0; rq[1] = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!rq[0]) rq[0] = ($urandom_range(2) == 0);
      else if (grant_a) rq[0] = ($urandom_range(3) != 0);
      if (!rq[1]) rq[1] = ($urandom_range(2) == 0);
      else if (grant_b) rq[1] = ($urandom_range(3) != 0);
      step(rq[0], rq[1]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
